uart_autobaud: RTL and testbench

Automatic baud-rate configuration controller for the UART. After being armed it measures the start bit and first data bit of a 0x55 sync character on the receive line, classifies the measured bit period against the four supported rates, and drives the 2-bit `bd_rate` select of the baud generator. It sits between the raw `rx` pin and the baud generator's rate-select input and replaces a static rate strap.

---
 rtl/uart_autobaud.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_autobaud.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud.sv
// uart_autobaud: measures the start bit and first data bit of a 0x55 sync
// character on rx, classifies the bit period against 1200/2400/4800/9600
// baud and drives the baud generator rate select.
//
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   start    single-cycle arm pulse (restarts detection from any state)
//   rx       asynchronous UART receive line, idles high
//   bd_rate  rate select (00:1200, 01:2400, 10:4800, 11:9600)
//   locked   a valid rate was detected since the last arm
//   error    detection failed since the last arm
//   busy     detection in progress
//
// Optional feature: define UART_AUTOBAUD_TIMEOUT_EN to fail detection when
// no start bit arrives within TIMEOUT_CYCLES of the arm pulse.
module uart_autobaud #(
   parameter int unsigned CLK_FREQ       = 50000000,
   parameter logic [1:0]  DEFAULT_RATE   = 2'b11,
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rx,
   output logic [1:0] bd_rate,
   output logic       locked,
   output logic       error,
   output logic       busy
);

   // Thresholds are midpoints between adjacent bit periods, computed from the
   // exact period fractions so no per-rate rounding accumulates.
   localparam int unsigned T_MIN = CLK_FREQ / 19200;
   localparam int unsigned T_A   = (CLK_FREQ * 3) / 19200;
   localparam int unsigned T_B   = (CLK_FREQ * 3) / 9600;
   localparam int unsigned T_C   = (CLK_FREQ * 3) / 4800;
   localparam int unsigned T_MAX = (CLK_FREQ * 3) / 2400;
   localparam int unsigned CW    = $clog2(T_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_IDLE, S_WAIT_FALL, S_MEAS_LOW, S_MEAS_HIGH, S_DONE, S_FAIL
   } state_t;

   typedef struct packed {
      logic       glitch;
      logic       invalid;
      logic [1:0] rate;
   } class_t;

   state_t          state_q, state_d;
   logic [1:0]      sync_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      cls_q, cls_d;
   logic [1:0]      bd_rate_q, bd_rate_d;
   logic            locked_q, locked_d;
   logic            error_q, error_d;
   logic            busy_q, busy_d;
   logic            rx_s;
   logic            timeout_hit;
   class_t          meas_c;

   assign rx_s = sync_q[1];

   // Map a measured width to a rate class.
   function automatic class_t classify(input logic [CW-1:0] w);
      class_t c;
      c = '{glitch: 1'b0, invalid: 1'b0, rate: 2'b00};
      if (w < CW'(T_MIN))      c.glitch  = 1'b1;
      else if (w < CW'(T_A))   c.rate    = 2'b11;
      else if (w < CW'(T_B))   c.rate    = 2'b10;
      else if (w < CW'(T_C))   c.rate    = 2'b01;
      else if (w < CW'(T_MAX)) c.rate    = 2'b00;
      else                     c.invalid = 1'b1;
      return c;
   endfunction

   assign meas_c = classify(cnt_q);

`ifdef UART_AUTOBAUD_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          to_en_q, to_en_d;

   // Arm-to-first-edge timer; disabled once a start bit has been seen.
   always_comb begin
      to_cnt_d = to_cnt_q;
      to_en_d  = to_en_q;
      if (start) begin
         to_cnt_d = '0;
         to_en_d  = 1'b1;
      end else if (state_d == S_MEAS_LOW || state_q == S_IDLE) begin
         to_en_d  = 1'b0;
      end else if (to_en_q && !timeout_hit &&
                   (state_q == S_WAIT_IDLE || state_q == S_WAIT_FALL)) begin
         to_cnt_d = to_cnt_q + TW'(1);
      end
   end

   assign timeout_hit = to_en_q && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt_q <= '0;
         to_en_q  <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         to_en_q  <= to_en_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
   // TIMEOUT_CYCLES is only consumed by the timeout build.
   if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
   end
`endif

   // Next-state and output logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cls_d     = cls_q;
      bd_rate_d = bd_rate_q;
      locked_d  = locked_q;
      error_d   = error_q;
      busy_d    = busy_q;

      case (state_q)
         S_IDLE: ;
         S_WAIT_IDLE: begin
            if (!rx_s) begin
               cnt_d = '0;
            end else if (cnt_q == CW'(T_MIN - 1)) begin
               cnt_d   = '0;
               state_d = S_WAIT_FALL;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT_FALL: begin
            if (!rx_s) begin
               cnt_d   = CW'(1);
               state_d = S_MEAS_LOW;
            end
         end
         S_MEAS_LOW: begin
            if (!rx_s) begin
               // Line held low past the longest valid bit: break condition.
               if (cnt_q == CW'(T_MAX - 1)) begin
                  cnt_d   = CW'(T_MAX);
                  state_d = S_FAIL;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else if (meas_c.glitch) begin
               state_d = S_WAIT_FALL;
            end else if (meas_c.invalid) begin
               state_d = S_FAIL;
            end else begin
               cls_d   = meas_c.rate;
               cnt_d   = CW'(1);
               state_d = S_MEAS_HIGH;
            end
         end
         S_MEAS_HIGH: begin
            if (rx_s) begin
               if (cnt_q == CW'(T_MAX - 1)) begin
                  cnt_d   = CW'(T_MAX);
                  state_d = S_FAIL;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else if (!meas_c.glitch && !meas_c.invalid && meas_c.rate == cls_q) begin
               state_d = S_DONE;
            end else begin
               state_d = S_FAIL;
            end
         end
         S_DONE: begin
            bd_rate_d = cls_q;
            locked_d  = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
         end
         S_FAIL: begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (timeout_hit && (state_q == S_WAIT_IDLE || state_q == S_WAIT_FALL) &&
          state_d != S_MEAS_LOW) begin
         state_d = S_FAIL;
      end

      // Arm pulse restarts detection from any state.
      if (start) begin
         state_d  = S_WAIT_IDLE;
         cnt_d    = '0;
         locked_d = 1'b0;
         error_d  = 1'b0;
         busy_d   = 1'b1;
      end
   end

   // State, synchronizer and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q    <= 2'b11;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         cls_q     <= DEFAULT_RATE;
         bd_rate_q <= DEFAULT_RATE;
         locked_q  <= 1'b0;
         error_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], rx};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cls_q     <= cls_d;
         bd_rate_q <= bd_rate_d;
         locked_q  <= locked_d;
         error_q   <= error_d;
         busy_q    <= busy_d;
      end
   end

   assign bd_rate = bd_rate_q;
   assign locked  = locked_q;
   assign error   = error_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Testbench for uart_autobaud. The DUT runs at CLK_FREQ = 5 MHz so all bit
// widths are one tenth of their 50 MHz values: thresholds 260/781/1562/3125/6250,
// bit periods 521 (9600), 1042 (4800), 2083 (2400), 4167 (1200).
module tb_uart_autobaud;

   logic       clk;
   logic       reset;
   logic       start;
   logic       rx;
   logic [1:0] bd_rate;
   logic       locked;
   logic       error;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   uart_autobaud #(
      .CLK_FREQ      (5000000),
      .DEFAULT_RATE  (2'b11),
      .TIMEOUT_CYCLES(1000)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .rx     (rx),
      .bd_rate(bd_rate),
      .locked (locked),
      .error  (error),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      rx    = 1'b1;
      step(3);
      reset = 1'b0;
      step(2);
   endtask

   // Pulse start with rx idle, then keep the line idle for 300 clk.
   task automatic arm();
      rx    = 1'b1;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(300);
   endtask

   task automatic wait_done(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         step(1);
         if (locked || error) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic frame(input int lo, input int hi);
      rx = 1'b0; step(lo);
      rx = 1'b1; step(hi);
      rx = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; rx = 1'b1;
      step(2);
      n_checks++; if (bd_rate !== 2'b11) begin n_fail++; $display("FAIL reset_bd_rate: got %b want 11", bd_rate); end
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      reset = 1'b0;
      step(2);
   endtask

   task automatic test_lock_9600();
      arm();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b9600_busy_armed: got %b want 1", busy); end
      frame(521, 521);
      step(3);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL b9600_locked_early: got %b want 0", locked); end
      step(1);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL b9600_locked_4clk: got %b want 1", locked); end
      n_checks++; if (bd_rate !== 2'b11) begin n_fail++; $display("FAIL b9600_bd_rate: got %b want 11", bd_rate); end
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL b9600_error: got %b want 0", error); end
      rx = 1'b1;
      step(20);
   endtask

   task automatic test_lock_1200();
      arm();
      frame(4167, 4167);
      step(3);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b1200_busy_before: got %b want 1", busy); end
      step(1);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL b1200_locked: got %b want 1", locked); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b1200_busy_with_lock: got %b want 0", busy); end
      n_checks++; if (bd_rate !== 2'b00) begin n_fail++; $display("FAIL b1200_bd_rate: got %b want 00", bd_rate); end
      rx = 1'b1;
      step(20);
   endtask

   task automatic test_glitch();
      bit ok;
      arm();
      rx = 1'b0; step(100);
      rx = 1'b1; step(300);
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL glitch_no_error: got %b want 0", error); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_still_busy: got %b want 1", busy); end
      frame(2083, 2083);
      wait_done(20, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL glitch_wait: got no lock/error want lock within 20 clk"); end
      n_checks++; if (bd_rate !== 2'b01) begin n_fail++; $display("FAIL glitch_bd_rate: got %b want 01", bd_rate); end
      n_checks++; if (locked !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL glitch_lock: got locked=%b error=%b want 1/0", locked, error); end
      rx = 1'b1;
      step(20);
   endtask

   task automatic test_reset_mid();
      bit ok;
      arm();
      rx = 1'b0;
      step(202);
      n_checks++; if (busy !== 1'b1 || bd_rate !== 2'b01) begin n_fail++; $display("FAIL rmid_pre: got busy=%b bd_rate=%b want 1/01", busy, bd_rate); end
      reset = 1'b1;
      #1;
      n_checks++; if (bd_rate !== 2'b11) begin n_fail++; $display("FAIL rmid_bd_rate: got %b want 11", bd_rate); end
      n_checks++; if (busy !== 1'b0 || locked !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: got busy=%b locked=%b error=%b want 0/0/0", busy, locked, error); end
      rx = 1'b1;
      step(2);
      reset = 1'b0;
      step(2);
      arm();
      frame(1042, 1042);
      wait_done(20, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_wait: got no lock/error want lock within 20 clk"); end
      n_checks++; if (bd_rate !== 2'b10 || locked !== 1'b1) begin n_fail++; $display("FAIL rmid_4800: got bd_rate=%b locked=%b want 10/1", bd_rate, locked); end
      rx = 1'b1;
      step(20);
   endtask

   task automatic test_mismatch();
      bit ok;
      do_reset();
      arm();
      frame(521, 1042);
      wait_done(20, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL mism_wait: got no lock/error want error within 20 clk"); end
      n_checks++; if (error !== 1'b1 || locked !== 1'b0) begin n_fail++; $display("FAIL mism_flags: got error=%b locked=%b want 1/0", error, locked); end
      n_checks++; if (bd_rate !== 2'b11) begin n_fail++; $display("FAIL mism_bd_rate: got %b want 11", bd_rate); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mism_busy: got %b want 0", busy); end
      rx = 1'b1;
      step(20);
   endtask

   task automatic test_break();
      arm();
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL brk_cleared: got %b want 0", error); end
      rx = 1'b0;
      step(2);
      step(6248);
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL brk_early: got %b want 0", error); end
      step(5);
      n_checks++; if (error !== 1'b1 || locked !== 1'b0) begin n_fail++; $display("FAIL brk_error: got error=%b locked=%b want 1/0", error, locked); end
      rx = 1'b1;
      step(20);
   endtask

   task automatic test_timeout();
      rx    = 1'b1;
      start = 1'b1;
      step(1);
      start = 1'b0;
`ifdef UART_AUTOBAUD_TIMEOUT_EN
      step(990);
      n_checks++; if (error !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early: got error=%b busy=%b want 0/1", error, busy); end
      step(20);
      n_checks++; if (error !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_fire: got error=%b busy=%b want 1/0", error, busy); end
`else
      step(5000);
      n_checks++; if (busy !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL tmo_none: got busy=%b error=%b want 1/0", busy, error); end
`endif
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      rx    = 1'b1;
      test_reset();
      test_lock_9600();
      test_lock_1200();
      test_glitch();
      test_reset_mid();
      test_mismatch();
      test_break();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
